spi_slave_responder: RTL and testbench
======================================

// Module: spi_slave_responder
// PURPOSE
//  SPI slave (responder) for the far end of the team's SPI master link: plays the role of the ADC/DAC.
//  Used as an in-FPGA loopback target for bring-up and as a synthesizable slave model in benches.
//  Oversamples sclk/ss/mosi in the system clock domain, shifts a WIDTH-bit frame in and out, and
//  hands received words to user logic via a one-cycle valid strobe. Transmit words arrive through a valid/ready handshake.
//  CPOL=0 only. clk must be >= 4x sclk.
// PARAMETERS
//  WIDTH        16       frame length in bits, MSB first in both directions
//  CPHA         0        0: sample mosi on sclk rise, shift miso on fall; 1: shift on rise, sample on fall
//  SYNC_STAGES  2        flops per input synchronizer (>=2)
//  DEFAULT_TX   16'h0000 word shifted out when no tx word is pending (underrun)
// PORTS
//  clk         in   1      system clock; all logic on rising edge
//  rst         in   1      synchronous, active-high reset
//  sclk        in   1      SPI clock from master (asynchronous)
//  ss          in   1      SPI slave select, active low (asynchronous)
//  mosi        in   1      SPI data from master (asynchronous)
//  miso        out  1      SPI data to master
//  miso_oe     out  1      high while a frame is selected (synced ss low)
//  tx_data     in   WIDTH  next word to send
//  tx_valid    in   1      tx_data valid
//  tx_ready    out  1      single-entry tx buffer empty
//  rx_data     out  WIDTH  last complete received word
//  rx_valid    out  1      one-cycle strobe: rx_data updated
//  tx_underrun out  1      one-cycle strobe: frame started with empty tx buffer
//  frame_err   out  1      one-cycle strobe: ss released before WIDTH bits
//  frame_cnt   out  16     completed-frame counter, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: miso=0, miso_oe=0, tx_ready=1, rx_data=0, all strobes=0, frame_cnt=0, tx buffer empty, state=WAIT_IDLE.
//  Inputs pass SYNC_STAGES synchronizers; edge detect on synced sclk/ss. Pin-to-action latency is SYNC_STAGES+1 clk.
//  States: WAIT_IDLE -> IDLE when synced ss=1 (so a reset mid-frame ignores the rest of that frame).
//   IDLE -> SHIFT on ss falling edge: load tx_shift from buffer (tx_ready->1 next cycle), else DEFAULT_TX and pulse
//   tx_underrun. bit_cnt=0. With CPHA=0 miso presents MSB at the cycle after ss fall.
//   SHIFT: sample edge shifts mosi into rx_shift LSB and increments bit_cnt. Shift edge shifts tx_shift left.
//   With CPHA=1 the first shift edge presents the MSB instead of shifting.
//   bit_cnt==WIDTH after a sample -> rx_data<=rx_shift, rx_valid=1 for one cycle, frame_cnt+1, -> DONE.
//   SHIFT with ss rising edge and bit_cnt<WIDTH -> frame_err pulse, rx_data unchanged, -> IDLE.
//   DONE: further sclk edges ignored, miso held 0. ss rising edge -> IDLE.
//  tx handshake: transfer when tx_valid&&tx_ready. A word accepted in the same cycle as an ss falling edge is
//   not used by that frame; it is held for the next frame, and that frame's tx_underrun fires.
//  miso = tx_shift[WIDTH-1] while in SHIFT, else 0. miso_oe = ~ss_sync.
//  bit_cnt width $clog2(WIDTH+1). rx_valid and frame_err are never asserted in the same cycle.
// STRUCTURE
//  spi_pkg: state enum {WAIT_IDLE, IDLE, SHIFT, DONE} and CPHA mode constants.
//  Sub-module spi_sync (SYNC_STAGES-deep flop chain, reset to 1 for ss and 0 for sclk/mosi),
//   with three instances. The FSM, shifters and counters live in this module.
// TESTING (WIDTH=16, clk 100 MHz, sclk 10 MHz unless noted)
//  1. Push tx 16'hA5C3, master sends 16'h1234. Expect miso bits A5C3 MSB-first, one rx_valid with
//     rx_data=16'h1234, and frame_cnt=1.
//  2. Frame with tx buffer empty. Expect miso 16'h0000, one tx_underrun, and rx_valid still fires.
//  3. ss released after 7 bits. Expect frame_err once, no rx_valid, rx_data unchanged. The next full
//     frame 16'hBEEF is received correctly.
//  4. 20 sclk pulses in one frame with mosi = 16'hF00F then 4'hA. Expect rx_data=16'hF00F, a single
//     rx_valid, and the extra edges ignored.
//  5. rst pulsed at bit 5 with ss held low. Expect all outputs at reset values and no strobes until ss
//     rises. The following frame works normally.
//  6. CPHA=1 build, back-to-back frames, tx 16'h0001 then 16'h8000 pushed as tx_ready allows. Expect the
//     words on miso in order, no underrun, and frame_cnt=2.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared FSM encoding and clock-phase constants for the SPI slave responder.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam int CPHA_SAMPLE_RISE = 0;
    localparam int CPHA_SAMPLE_FALL = 1;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer bringing an asynchronous SPI pin into the clk domain.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_responder.sv
// Oversampled SPI slave (CPOL=0): shifts a WIDTH-bit frame each way, single-entry tx buffer,
// one-cycle rx/underrun/frame-error strobes and a completed-frame counter.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               CPHA        = 0,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] DEFAULT_TX  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam int CNT_W    = $clog2(WIDTH + 1);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic sclk_s, ss_s, mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk), .dout(sclk_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .din(ss), .dout(ss_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s));

    state_e               state_q, state_d;
    logic                 sclk_prev_q, ss_prev_q;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic [WIDTH-1:0]     tx_buf_q, tx_buf_d;
    logic                 tx_full_q, tx_full_d;
    logic [WIDTH-1:0]     tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0]     rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0]     rx_data_q, rx_data_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic                 first_shift_q, first_shift_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 tx_underrun_q, tx_underrun_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;

    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic sample_edge, shift_edge, tx_accept;

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign ss_fall     = ~ss_s & ss_prev_q;
    assign ss_rise     = ss_s & ~ss_prev_q;
    assign sample_edge = (CPHA == CPHA_SAMPLE_RISE) ? sclk_rise : sclk_fall;
    assign shift_edge  = (CPHA == CPHA_SAMPLE_RISE) ? sclk_fall : sclk_rise;
    assign tx_accept   = tx_valid & ~tx_full_q;
    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        settle_d      = settle_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        bit_cnt_d     = bit_cnt_q;
        first_shift_d = first_shift_q;
        frame_cnt_d   = frame_cnt_q;
        rx_valid_d    = 1'b0;
        frame_err_d   = 1'b0;
        tx_underrun_d = 1'b0;

        // Synchronizers still hold their reset value until the chain has refilled.
        if (settle_q != SETTLE_W'(SYNC_STAGES)) begin
            settle_d = settle_q + SETTLE_W'(1);
        end

        // A word accepted alongside an ss fall waits for the next frame.
        if (tx_accept) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end

        case (state_q)
            ST_WAIT_IDLE: begin
                if (settle_q == SETTLE_W'(SYNC_STAGES) && ss_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ss_fall) begin
                    state_d       = ST_SHIFT;
                    bit_cnt_d     = '0;
                    rx_shift_d    = '0;
                    first_shift_d = 1'b1;
                    if (tx_full_q) begin
                        tx_shift_d = tx_buf_q;
                        tx_full_d  = 1'b0;
                    end else begin
                        tx_shift_d    = DEFAULT_TX;
                        tx_underrun_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_inc;
                    if (bit_cnt_inc == CNT_W'(WIDTH)) begin
                        rx_data_d   = rx_shift_d;
                        rx_valid_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = ST_DONE;
                    end
                end else if (shift_edge) begin
                    first_shift_d = 1'b0;
                    // In CPHA=1 the leading edge only presents the MSB that is already on miso.
                    if (!(CPHA == CPHA_SAMPLE_FALL && first_shift_q)) begin
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            ST_DONE: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_WAIT_IDLE;
            sclk_prev_q   <= 1'b0;
            ss_prev_q     <= 1'b1;
            settle_q      <= '0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            bit_cnt_q     <= '0;
            first_shift_q <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sclk_prev_q   <= sclk_s;
            ss_prev_q     <= ss_s;
            settle_q      <= settle_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            bit_cnt_q     <= bit_cnt_d;
            first_shift_q <= first_shift_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            tx_underrun_q <= tx_underrun_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Stay off the bus while the remainder of a frame interrupted by reset goes by.
    assign miso_oe     = ~ss_s & (state_q != ST_WAIT_IDLE);
    assign miso        = (state_q == ST_SHIFT) ? tx_shift_q[WIDTH-1] : 1'b0;
    assign tx_ready    = ~tx_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Randomized bench for spi_slave_responder: a CPHA=0 and a CPHA=1 instance driven by one bit-level master.
`timescale 1ns/1ps
module tb_spi_slave_responder;

    localparam int         W     = 16;
    localparam int         HALF  = 50;
    localparam logic [W-1:0] DEF0 = 16'h0000;
    localparam logic [W-1:0] DEF1 = 16'hC3A5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic m_sclk, m_ss, m_mosi, mode_sel;
    logic [W-1:0] tx_data;
    logic tx_valid;

    logic ss0, ss1, tv0, tv1;
    logic miso0, oe0, rdy0, rxv0, und0, ferr0;
    logic miso1, oe1, rdy1, rxv1, und1, ferr1;
    logic [W-1:0] rxd0, rxd1;
    logic [15:0] fc0, fc1;

    assign ss0 = mode_sel ? 1'b1 : m_ss;
    assign ss1 = mode_sel ? m_ss : 1'b1;
    assign tv0 = tx_valid & ~mode_sel;
    assign tv1 = tx_valid & mode_sel;

    spi_slave_responder #(.WIDTH(W), .CPHA(0), .SYNC_STAGES(2), .DEFAULT_TX(DEF0)) dut (
        .clk(clk), .rst(rst), .sclk(m_sclk), .ss(ss0), .mosi(m_mosi),
        .miso(miso0), .miso_oe(oe0), .tx_data(tx_data), .tx_valid(tv0), .tx_ready(rdy0),
        .rx_data(rxd0), .rx_valid(rxv0), .tx_underrun(und0), .frame_err(ferr0), .frame_cnt(fc0));

    spi_slave_responder #(.WIDTH(W), .CPHA(1), .SYNC_STAGES(2), .DEFAULT_TX(DEF1)) dut_cpha1 (
        .clk(clk), .rst(rst), .sclk(m_sclk), .ss(ss1), .mosi(m_mosi),
        .miso(miso1), .miso_oe(oe1), .tx_data(tx_data), .tx_valid(tv1), .tx_ready(rdy1),
        .rx_data(rxd1), .rx_valid(rxv1), .tx_underrun(und1), .frame_err(ferr1), .frame_cnt(fc1));

    logic miso_m, oe_m, rdy_m, rxv_m, und_m, ferr_m;
    logic [W-1:0] rxd_m, def_m;
    logic [15:0] fc_m;
    assign miso_m = mode_sel ? miso1 : miso0;
    assign oe_m   = mode_sel ? oe1   : oe0;
    assign rdy_m  = mode_sel ? rdy1  : rdy0;
    assign rxv_m  = mode_sel ? rxv1  : rxv0;
    assign und_m  = mode_sel ? und1  : und0;
    assign ferr_m = mode_sel ? ferr1 : ferr0;
    assign rxd_m  = mode_sel ? rxd1  : rxd0;
    assign fc_m   = mode_sel ? fc1   : fc0;
    assign def_m  = mode_sel ? DEF1  : DEF0;

    int rxv_tot = 0, ferr_tot = 0, und_tot = 0, both_tot = 0;
    always @(negedge clk) begin
        if (rxv_m)  rxv_tot++;
        if (ferr_m) ferr_tot++;
        if (und_m)  und_tot++;
        if ((rxv0 && ferr0) || (rxv1 && ferr1)) both_tot++;
    end

    // Reference model: pending tx words, last good rx word, completed frames.
    logic [W-1:0] tx_q[$];
    logic [W-1:0] exp_rx;
    logic [15:0]  exp_fc;

    int n_vec = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        tx_q.delete();
        exp_rx = '0;
        exp_fc = '0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        int waited;
        waited = 0;
        @(posedge clk); #1;
        while (rdy_m !== 1'b1 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check_eq("tx_ready_before_push", 32'(rdy_m), 32'(tx_q.size() == 0));
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_q.push_back(w);
    endtask

    // One master transaction of nbits sclk pulses; mosi_word sent MSB-first from bit nbits-1.
    task automatic spi_frame(input logic [31:0] mosi_word, input int nbits,
                             input bit late_push, input logic [W-1:0] late_word);
        logic [31:0] miso_word, exp_miso;
        logic [W-1:0] used;
        bit   und_exp;
        logic oe_seen;
        int   rxv_s, ferr_s, und_s;
        und_exp   = (tx_q.size() == 0);
        used      = und_exp ? def_m : tx_q.pop_front();
        rxv_s     = rxv_tot;
        ferr_s    = ferr_tot;
        und_s     = und_tot;
        miso_word = '0;
        @(posedge clk); #1;
        m_mosi = mosi_word[nbits-1];
        m_ss   = 1'b0;
        if (late_push) begin
            // Offer a word on exactly the cycle the responder acts on the ss fall.
            @(posedge clk); @(posedge clk); #1;
            tx_data  = late_word;
            tx_valid = 1'b1;
            @(posedge clk); #1;
            tx_valid = 1'b0;
            tx_q.push_back(late_word);
            #(HALF - 30);
        end else begin
            #(HALF);
        end
        oe_seen = oe_m;
        for (int i = 0; i < nbits; i++) begin
            if (!mode_sel) begin
                miso_word = {miso_word[30:0], miso_m};
                m_sclk = 1'b1;
                #(HALF);
                m_sclk = 1'b0;
                if (i + 1 < nbits) m_mosi = mosi_word[nbits-2-i];
                #(HALF);
            end else begin
                m_sclk = 1'b1;
                m_mosi = mosi_word[nbits-1-i];
                #(HALF);
                miso_word = {miso_word[30:0], miso_m};
                m_sclk = 1'b0;
                #(HALF);
            end
        end
        m_ss   = 1'b1;
        m_mosi = 1'b0;
        #(2*HALF);
        if (nbits >= W) begin
            exp_miso = {16'h0, used} << (nbits - W);
            exp_rx   = W'(mosi_word >> (nbits - W));
            exp_fc   = exp_fc + 16'd1;
        end else begin
            exp_miso = {16'h0, used} >> (W - nbits);
        end
        check_eq("miso_bits", miso_word, exp_miso);
        check_eq("miso_oe_in_frame", 32'(oe_seen), 32'd1);
        check_eq("miso_oe_after", 32'(oe_m), 32'd0);
        check_eq("rx_valid_count", 32'(rxv_tot - rxv_s), 32'(nbits >= W));
        check_eq("frame_err_count", 32'(ferr_tot - ferr_s), 32'(nbits < W));
        check_eq("underrun_count", 32'(und_tot - und_s), 32'(und_exp));
        check_eq("rx_data", 32'(rxd_m), 32'(exp_rx));
        check_eq("frame_cnt", 32'(fc_m), 32'(exp_fc));
        check_eq("tx_ready", 32'(rdy_m), 32'(tx_q.size() == 0));
        $display("frame cpha=%0d bits=%0d mosi=%h miso=%h rx=%h cnt=%0d",
                 mode_sel, nbits, mosi_word, miso_word, rxd_m, fc_m);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int   nb, rxv_s, ferr_s, und_s;
        logic quiet;
        rst = 1'b1; m_sclk = 1'b0; m_ss = 1'b1; m_mosi = 1'b0; mode_sel = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        tx_q.delete(); exp_rx = '0; exp_fc = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_miso", 32'(miso_m), 32'd0);
        check_eq("reset_miso_oe", 32'(oe_m), 32'd0);
        check_eq("reset_tx_ready", 32'(rdy_m), 32'd1);
        check_eq("reset_rx_data", 32'(rxd_m), 32'd0);
        check_eq("reset_strobes", {29'd0, rxv_m, und_m, ferr_m}, 32'd0);
        check_eq("reset_frame_cnt", 32'(fc_m), 32'd0);
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // Directed CPHA=0 cases
        push_tx(16'hA5C3);
        spi_frame(32'h1234, 16, 1'b0, '0);
        spi_frame($urandom, 16, 1'b0, '0);
        push_tx(16'h5A5A);
        spi_frame($urandom, 7, 1'b0, '0);
        push_tx(W'($urandom));
        spi_frame(32'hBEEF, 16, 1'b0, '0);
        push_tx(W'($urandom));
        spi_frame(32'hF00FA, 20, 1'b0, '0);

        // Reset with ss held low at bit 5
        @(posedge clk); #1;
        m_mosi = 1'b1;
        m_ss   = 1'b0;
        #(HALF);
        for (int i = 0; i < 5; i++) begin
            m_sclk = 1'b1; #(HALF); m_sclk = 1'b0; #(HALF);
        end
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        tx_q.delete(); exp_rx = '0; exp_fc = '0;
        check_eq("midreset_tx_ready", 32'(rdy_m), 32'd1);
        check_eq("midreset_rx_data", 32'(rxd_m), 32'd0);
        check_eq("midreset_frame_cnt", 32'(fc_m), 32'd0);
        rxv_s = rxv_tot; ferr_s = ferr_tot; und_s = und_tot;
        quiet = 1'b0;
        for (int i = 0; i < 11; i++) begin
            m_sclk = 1'b1; #(HALF);
            quiet = quiet | oe_m | miso_m;
            m_sclk = 1'b0; #(HALF);
        end
        m_ss = 1'b1;
        #(2*HALF);
        check_eq("midreset_bus_quiet", 32'(quiet), 32'd0);
        check_eq("midreset_strobes", 32'((rxv_tot - rxv_s) + (ferr_tot - ferr_s) + (und_tot - und_s)), 32'd0);
        spi_frame($urandom, 16, 1'b0, '0);

        // Word accepted on the ss-fall cycle belongs to the following frame
        spi_frame($urandom, 16, 1'b1, 16'h6B2D);
        spi_frame($urandom, 16, 1'b0, '0);

        for (int k = 0; k < 10; k++) begin
            r = $urandom_range(0, 5);
            nb = (r == 0) ? int'($urandom_range(1, 15)) : (r == 1) ? int'($urandom_range(17, 24)) : 16;
            if ($urandom_range(0, 1) == 1 && tx_q.size() == 0) push_tx(W'($urandom));
            spi_frame($urandom, nb, 1'b0, '0);
        end

        // CPHA=1 instance
        mode_sel = 1'b1;
        do_reset();
        push_tx(16'h0001);
        fork
            spi_frame($urandom, 16, 1'b0, '0);
            begin
                #(3*HALF);
                push_tx(16'h8000);
            end
        join
        spi_frame($urandom, 16, 1'b0, '0);
        for (int k = 0; k < 6; k++) begin
            r = $urandom_range(0, 3);
            nb = (r == 0) ? int'($urandom_range(1, 15)) : (r == 1) ? int'($urandom_range(17, 22)) : 16;
            if ($urandom_range(0, 1) == 1 && tx_q.size() == 0) push_tx(W'($urandom));
            spi_frame($urandom, nb, 1'b0, '0);
        end

        check_eq("rx_valid_with_frame_err", 32'(both_tot), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
